// File: rtl/uart_tx_if.sv
// Byte-send handshake and serial line of the UART transmitter.
// The master side issues send requests; the slave side (the transmitter) drives status and the line.
interface uart_tx_if;
  logic       send_en;
  logic [7:0] send_data;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_txd;

  modport master (
    output send_en,
    output send_data,
    input  tx_busy,
    input  tx_done,
    input  uart_txd
  );

  modport slave (
    input  send_en,
    input  send_data,
    output tx_busy,
    output tx_done,
    output uart_txd
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
// A rising edge on send_en while idle latches send_data and sends start, D0..D7, stop.
// Each bit is held for CLK_FREQ/UART_BPS clocks.
// Requests made while a frame is in flight are dropped.
module uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  uart_tx_if.slave bus
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             en_q_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_r, bit_s;
  logic [7:0]       shift_r, shift_s;
  logic             txd_r, txd_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             req_s;
  logic             bit_end_s;

  // A request is only the 0->1 transition of send_en, seen in the current cycle.
  assign req_s     = bus.send_en & ~en_q_r;
  assign bit_end_s = (cnt_r == CNT_LAST);

  assign bus.uart_txd = txd_r;
  assign bus.tx_busy  = busy_r;
  assign bus.tx_done  = done_r;

  // State and datapath registers with synchronous reset to the idle line state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r <= IDLE;
      en_q_r  <= 1'b0;
      cnt_r   <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      en_q_r  <= bus.send_en;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      txd_r   <= txd_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-output logic.
  // The line value is computed one cycle ahead so that uart_txd is a pure register.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s = START;
          shift_s = bus.send_data;
          txd_s   = 1'b0;
          busy_s  = 1'b1;
          cnt_s   = '0;
          bit_s   = 3'd0;
        end else begin
          txd_s  = 1'b1;
          busy_s = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          state_s = DATA;
          txd_s   = shift_r[0];
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = '0;
          if (bit_r == 3'd7) begin
            state_s = STOP;
            bit_s   = 3'd0;
            txd_s   = 1'b1;
          end else begin
            bit_s = bit_r + 3'd1;
            txd_s = shift_r[bit_r + 3'd1];
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_s) begin
          cnt_s   = '0;
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        bit_s   = 3'd0;
        txd_s   = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with 10 clocks per bit.
// Frame cycle k = 1 is the first cycle after the accepting edge; frame ends at k = 100.
module tb_uart_tx;

  localparam int BPS = 10;

  logic sys_clk;
  logic sys_rst;
  int   errors;
  int   checks;

  uart_tx_if bus ();

  uart_tx #(
    .CLK_FREQ (40),
    .UART_BPS (4)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Expected line level in frame cycle k (1..100) for byte d.
  function automatic logic exp_txd(input logic [7:0] d, input int k);
    int idx;
    idx = (k - 1) / BPS;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx - 1];
    else return 1'b1;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d: txd=%b busy=%b done=%b, want 1 0 0", i, bus.uart_txd, bus.tx_busy, bus.tx_done);
      end
    end
  endtask

  task automatic test_reset_release();
    sys_rst = 1'b0;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'h01, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL rel_01 k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'h01, k));
      end
      tick();
    end
    checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL rel_01 end: txd=%b busy=%b done=%b, want 1 0 1", bus.uart_txd, bus.tx_busy, bus.tx_done);
    end
    bus.send_en = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus.send_en = 1'b0;
    tick();
    bus.send_data = 8'hA5;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'hA5, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL a5 k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'hA5, k));
      end
      if (k == 50) bus.send_data = 8'h00;
      tick();
    end
    checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL a5 done: txd=%b busy=%b done=%b, want 1 0 1", bus.uart_txd, bus.tx_busy, bus.tx_done);
    end
    tick();
    checks++;
    if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL a5 after: busy=%b done=%b, want 0 0", bus.tx_busy, bus.tx_done);
    end
  endtask

  task automatic test_held_high();
    bus.send_en = 1'b0;
    tick();
    bus.send_data = 8'h5A;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'h5A, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL 5a k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'h5A, k));
      end
      tick();
    end
    checks++;
    if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL 5a done: busy=%b done=%b, want 0 1", bus.tx_busy, bus.tx_done);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL held_idle i=%0d: txd=%b busy=%b done=%b, want 1 0 0", i, bus.uart_txd, bus.tx_busy, bus.tx_done);
      end
    end
  endtask

  task automatic test_drop_busy();
    bus.send_en = 1'b0;
    tick();
    bus.send_data = 8'h0F;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'h0F, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL 0f k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'h0F, k));
      end
      if (k == 5) bus.send_en = 1'b0;
      if (k == 35) begin
        bus.send_data = 8'h3C;
        bus.send_en   = 1'b1;
      end
      tick();
    end
    checks++;
    if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL 0f done: busy=%b done=%b, want 0 1", bus.tx_busy, bus.tx_done);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle i=%0d: txd=%b busy=%b, want 1 0", i, bus.uart_txd, bus.tx_busy);
      end
    end
  endtask

  task automatic test_rst_mid();
    bus.send_en = 1'b0;
    tick();
    bus.send_data = 8'hFF;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 45; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'hFF, k) || bus.tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL ff k=%0d: txd=%b busy=%b, want %b 1", k, bus.uart_txd, bus.tx_busy, exp_txd(8'hFF, k));
      end
      if (k < 45) tick();
    end
    sys_rst     = 1'b1;
    bus.send_en = 1'b0;
    tick();
    checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: txd=%b busy=%b done=%b, want 1 0 0", bus.uart_txd, bus.tx_busy, bus.tx_done);
    end
    sys_rst = 1'b0;
    tick();
    checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_rel: txd=%b busy=%b done=%b, want 1 0 0", bus.uart_txd, bus.tx_busy, bus.tx_done);
    end
    bus.send_data = 8'h81;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'h81, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL 81 k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'h81, k));
      end
      tick();
    end
    checks++;
    if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL 81 done: busy=%b done=%b, want 0 1", bus.tx_busy, bus.tx_done);
    end
  endtask

  task automatic test_back_to_back();
    bus.send_en = 1'b0;
    tick();
    bus.send_data = 8'hC3;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'hC3, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL c3 k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'hC3, k));
      end
      if (k == 3) bus.send_en = 1'b0;
      tick();
    end
    checks++;
    if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL c3 done: busy=%b done=%b, want 0 1", bus.tx_busy, bus.tx_done);
    end
    bus.send_data = 8'h00;
    bus.send_en   = 1'b1;
    tick();
    for (int k = 1; k <= 100; k++) begin
      checks++;
      if (bus.uart_txd !== exp_txd(8'h00, k) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_00 k=%0d: txd=%b busy=%b done=%b, want %b 1 0", k, bus.uart_txd, bus.tx_busy, bus.tx_done, exp_txd(8'h00, k));
      end
      tick();
    end
    checks++;
    if (bus.uart_txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_00 done: txd=%b busy=%b done=%b, want 1 0 1", bus.uart_txd, bus.tx_busy, bus.tx_done);
    end
  endtask

  // Scenario sequence; every wait is a fixed number of clocks.
  initial begin
    errors        = 0;
    checks        = 0;
    sys_rst       = 1'b1;
    bus.send_en   = 1'b1;
    bus.send_data = 8'h01;
    test_reset();
    test_reset_release();
    test_basic();
    test_held_high();
    test_drop_busy();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, line baud rate in bit/s.
REQ-003 Derived constant BPS_CNT = CLK_FREQ / UART_BPS (integer, truncated) SHALL be the clocks per bit; BPS_CNT >= 2 is required, smaller values are unsupported.
REQ-004 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 sys_rst  input  1  reset, synchronous, active-high.
REQ-006 send_en  input  1  send request; level signal, only its 0->1 transition requests a frame.
REQ-007 send_data  input  8  byte to transmit; sampled only on an accepted request.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse at frame completion.
REQ-010 uart_txd  output  1  serial line, idle high.

Function
REQ-011 Frame format SHALL be 8N1: start bit 0, data bits D0..D7 LSB first, one stop bit 1; each bit held exactly BPS_CNT cycles.
REQ-012 Block SHALL register send_en each cycle (en_q); request = send_en & ~en_q, evaluated combinationally in the current cycle.
REQ-013 Request accepted only when state is IDLE (tx_busy=0); at that clock edge send_data latched into shift register, tx_busy<=1, uart_txd<=0, state<=START, bit clock counter<=0.
REQ-014 Request while tx_busy=1 SHALL be dropped, not queued; includes a request in the final cycle of the stop bit.
REQ-015 States: IDLE -> START (accepted request) -> DATA (after BPS_CNT cycles) -> STOP (after 8 bits of BPS_CNT cycles) -> IDLE (after BPS_CNT cycles).
REQ-016 Bit clock counter SHALL count 0..BPS_CNT-1 and wrap to 0 on each bit boundary; bit index counter 0..7 in DATA, cleared on entry to STOP.
REQ-017 uart_txd SHALL be a registered output, changing only on bit boundaries; in DATA it carries shift-register bit indexed by bit counter.
REQ-018 tx_busy SHALL remain high for exactly 10*BPS_CNT cycles per frame, falling on the edge that returns state to IDLE.
REQ-019 tx_done SHALL be 1 for exactly the single cycle following the edge where tx_busy falls; 0 otherwise.
REQ-020 Changes of send_data or send_en during a frame SHALL not affect the frame in progress.
REQ-021 New request accepted in the first cycle tx_busy=0; minimum gap between frames is therefore one clock plus request edge latency.

Reset
REQ-022 While sys_rst=1: uart_txd=1, tx_busy=0, tx_done=0, state IDLE, all counters 0, shift register 0, en_q=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame; outputs reach reset values at the next clock edge, no stop bit completion.
REQ-024 With en_q reset to 0, send_en already high in the first cycle after reset release SHALL count as a request and start a frame.

Verification (CLK_FREQ=40, UART_BPS=4, BPS_CNT=10)
REQ-025 send_data=0xA5, send_en 0->1 -> uart_txd: 0 x10, then 1,0,1,0,0,1,0,1 each x10, then 1 x10; tx_busy high 100 cycles; tx_done pulses once in cycle 101.
REQ-026 send_en held high after frame of 0x5A completes -> no second frame; uart_txd stays 1, tx_busy stays 0.
REQ-027 Frame of 0x0F started; at cycle 35 send_en toggled 0->1 with send_data=0x3C -> request dropped; line carries only 0x0F frame, tx_busy falls at cycle 100, no follow-on frame.
REQ-028 Frame of 0xFF started; sys_rst pulsed at cycle 45 (data bit 3) -> next cycle uart_txd=1, tx_busy=0, tx_done=0; new request 0x81 after release -> full correct 100-cycle frame.
REQ-029 send_en dropped low during frame, raised in cycle tx_done=1 with send_data=0x00 -> second frame starts that edge: start bit then ten cycles per bit of all zeros, stop 1.
REQ-030 send_en high at reset release with send_data=0x01 -> frame starts in first post-reset cycle, D0=1 then seven 0 bits.
